hazard_stall_ctrl: RTL

Parametrised load-use and memory-stall controller for the five-stage pipeline; the successor to the single-cycle load-use hazard detector. It sits beside the ID stage. It compares the IF/ID source registers against an in-flight load in ID/EX and generates PC/IF-ID hold, ID/EX bubble, whole-pipe freeze and IF/ID flush controls. It supports multi-cycle load-use penalties, data-memory wait stalls, branch-flush cancellation and a saturating stall-cycle counter.

---
 rtl/hazard_stall_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Load-use and memory-stall controller beside the ID stage: generates PC/IF-ID hold,
// ID/EX bubble, pipe freeze and IF/ID flush, with multi-cycle load-use penalty.
module hazard_stall_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned ZERO_EXEMPT = 1,
  parameter int unsigned PERF_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ID_EX_MemRead,
  input  logic [REG_AW-1:0] ID_EX_RegisterRt,
  input  logic [REG_AW-1:0] IF_ID_RegisterRs,
  input  logic [REG_AW-1:0] IF_ID_RegisterRt,
  input  logic              IF_ID_UseRs,
  input  logic              IF_ID_UseRt,
  input  logic              mem_stall_i,
  input  logic              branch_taken_i,
  output logic              pc_stall_o,
  output logic              if_id_stall_o,
  output logic              bubble_o,
  output logic              freeze_o,
  output logic              flush_o,
  output logic              lu_busy_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam int unsigned RW = $clog2(LOAD_LAT + 1);
  localparam logic [RW-1:0] REM_INIT = RW'(LOAD_LAT - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  state_t        state;
  logic [RW-1:0] rem;
  logic          hz;
  logic          rs_match;
  logic          rt_match;
  logic          zero_dst;

  assign rs_match  = IF_ID_UseRs && (IF_ID_RegisterRs == ID_EX_RegisterRt);
  assign rt_match  = IF_ID_UseRt && (IF_ID_RegisterRt == ID_EX_RegisterRt);
  assign zero_dst  = (ZERO_EXEMPT != 0) && (ID_EX_RegisterRt == '0);
  assign hz        = ID_EX_MemRead && (rs_match || rt_match) && !zero_dst;
  assign lu_busy_o = (state == LU_STALL);

  // Priority: reset, memory freeze, branch flush, then load-use stall.
  always_comb begin
    pc_stall_o    = 1'b0;
    if_id_stall_o = 1'b0;
    bubble_o      = 1'b0;
    freeze_o      = 1'b0;
    flush_o       = 1'b0;
    if (rst_i) begin
      pc_stall_o = 1'b0;
    end else if (mem_stall_i) begin
      freeze_o      = 1'b1;
      pc_stall_o    = 1'b1;
      if_id_stall_o = 1'b1;
    end else if (branch_taken_i) begin
      flush_o = 1'b1;
    end else if (state == LU_STALL || hz) begin
      pc_stall_o    = 1'b1;
      if_id_stall_o = 1'b1;
      bubble_o      = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rem         <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (pc_stall_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
      if (mem_stall_i) begin
        state <= state;
        rem   <= rem;
      end else if (branch_taken_i) begin
        state <= IDLE;
        rem   <= '0;
      end else if (state == LU_STALL) begin
        if (rem == RW'(1)) begin
          state <= IDLE;
          rem   <= '0;
        end else begin
          rem <= rem - 1'b1;
        end
      end else if (hz && (LOAD_LAT > 1)) begin
        state <= LU_STALL;
        rem   <= REM_INIT;
      end
    end
  end

endmodule
